lsu: RTL and testbench

- Load/store unit between exec and writeback. It owns the core data bus, which is an AXI4-lite master.
- Non-memory instructions pass through in one cycle.
- Loads and stores run a single AXI4-lite transaction each. The result or exception is presented to writeback with the standard pipeline handshake.
- One instruction is in flight at a time.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_if.sv | 38 +++
 rtl/lsu_lane.sv | 47 ++++
 rtl/lsu.sv | 173 +++++++++++++++++
 tb/tb_lsu.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access widths,
// AXI response codes and small address-alignment helpers.
package lsu_pkg;

   localparam int XLEN = 32;
   localparam int ALEN = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } lsu_state_t;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   function automatic logic funct3_valid(input logic [2:0] f);
      return (f == LSU_B) || (f == LSU_H) || (f == LSU_W) || (f == LSU_BU) || (f == LSU_HU);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] a);
      if (f == LSU_H || f == LSU_HU) return a[0];
      if (f == LSU_W) return a != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [1:0] force_align(input logic [2:0] f, input logic [1:0] a);
      if (f == LSU_H || f == LSU_HU) return {a[1], 1'b0};
      if (f == LSU_W) return 2'b00;
      return a;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// AXI4-lite bus between the load/store unit (master) and the data memory (slave).
interface lsu_if;
   logic        aclk;
   logic        aresetn;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output aclk, aresetn,
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  aclk, aresetn,
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: store strobe/data replication and load extract/extend.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      wstrb     = 4'b1111;
      wdata     = store_data;
      shifted   = rdata >> {addr_lo, 3'b000};
      load_data = rdata;
      case (funct3)
         LSU_B: begin
            wstrb     = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{shifted[7]}}, shifted[7:0]};
         end
         LSU_BU: begin
            wstrb     = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {24'h0, shifted[7:0]};
         end
         LSU_H: begin
            wstrb     = 4'b0011 << addr_lo;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{shifted[15]}}, shifted[15:0]};
         end
         LSU_HU: begin
            wstrb     = 4'b0011 << addr_lo;
            wdata     = {2{store_data[15:0]}};
            load_data = {16'h0, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one instruction in flight, one AXI4-lite transaction per load/store.
// LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
module lsu
   import lsu_pkg::*;
#(
   parameter logic [2:0] AXPROT = 3'b000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            prev_stalled,
   output logic            stall_prev,
   input  logic            next_stalled,
   output logic            stall_next,
   input  logic            exec_is_load,
   input  logic            exec_is_store,
   input  logic [2:0]      exec_funct3,
   input  logic [XLEN-1:0] exec_result,
   input  logic [XLEN-1:0] exec_store_data,
   input  logic            exec_is_reg_write,
   input  logic [4:0]      exec_reg_write_sel,
   input  logic            exec_exception,
   input  logic [ALEN-1:0] exec_instruction_next_addr,
   output logic [XLEN-1:0] lsu_result,
   output logic            lsu_is_reg_write,
   output logic [4:0]      lsu_reg_write_sel,
   output logic            lsu_exception,
   output logic [ALEN-1:0] lsu_instruction_next_addr,
   lsu_if.master           data_bus
);

   lsu_state_t  state;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic        is_reg_write_q;
   logic [31:0] bus_addr;

   logic        accept;
   logic [1:0]  addr_lo_in;
   logic        mis_trap;
   logic        mem_exc;
   logic [2:0]  lane_funct3;
   logic [1:0]  lane_addr;
   logic [3:0]  lane_wstrb;
   logic [31:0] lane_wdata;
   logic [31:0] lane_load;

   assign stall_next = (state != ST_DONE);
   assign stall_prev = !((state == ST_IDLE) || (state == ST_DONE && !next_stalled));
   assign accept     = !prev_stalled && !stall_prev;

`ifdef LSU_MISALIGN_TRAP_EN
   assign addr_lo_in = exec_result[1:0];
   assign mis_trap   = is_misaligned(exec_funct3, exec_result[1:0]);
`else
   assign addr_lo_in = force_align(exec_funct3, exec_result[1:0]);
   assign mis_trap   = 1'b0;
`endif
   assign mem_exc = !funct3_valid(exec_funct3) || mis_trap;

   // The lane serves the incoming store on accept and the latched load otherwise.
   assign lane_funct3 = accept ? exec_funct3 : funct3_q;
   assign lane_addr   = accept ? addr_lo_in  : addr_lo_q;

   lsu_lane u_lane (
      .funct3     (lane_funct3),
      .addr_lo    (lane_addr),
      .store_data (exec_store_data),
      .rdata      (data_bus.rdata),
      .wstrb      (lane_wstrb),
      .wdata      (lane_wdata),
      .load_data  (lane_load)
   );

   assign data_bus.aclk    = clk;
   assign data_bus.aresetn = !rst;
   assign data_bus.awaddr  = bus_addr;
   assign data_bus.araddr  = bus_addr;
   assign data_bus.awprot  = AXPROT;
   assign data_bus.arprot  = AXPROT;

   // NOTE: sequential state uses non-blocking assignments only; the later accept block
   // deliberately overrides the per-state defaults in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                     <= ST_IDLE;
         funct3_q                  <= '0;
         addr_lo_q                 <= '0;
         is_reg_write_q            <= 1'b0;
         bus_addr                  <= '0;
         data_bus.arvalid          <= 1'b0;
         data_bus.rready           <= 1'b0;
         data_bus.awvalid          <= 1'b0;
         data_bus.wvalid           <= 1'b0;
         data_bus.wdata            <= '0;
         data_bus.wstrb            <= '0;
         data_bus.bready           <= 1'b0;
         lsu_result                <= '0;
         lsu_is_reg_write          <= 1'b0;
         lsu_reg_write_sel         <= '0;
         lsu_exception             <= 1'b0;
         lsu_instruction_next_addr <= '0;
      end else begin
         case (state)
            ST_AR: if (data_bus.arready) begin
               data_bus.arvalid <= 1'b0;
               data_bus.rready  <= 1'b1;
               state            <= ST_R;
            end
            ST_R: if (data_bus.rvalid) begin
               data_bus.rready <= 1'b0;
               state           <= ST_DONE;
               if (data_bus.rresp != AXI_RESP_OKAY) begin
                  lsu_result       <= '0;
                  lsu_exception    <= 1'b1;
                  lsu_is_reg_write <= 1'b0;
               end else begin
                  lsu_result       <= lane_load;
                  lsu_exception    <= 1'b0;
                  lsu_is_reg_write <= is_reg_write_q;
               end
            end
            ST_AW_W: begin
               if (data_bus.awready) data_bus.awvalid <= 1'b0;
               if (data_bus.wready)  data_bus.wvalid  <= 1'b0;
               if ((!data_bus.awvalid || data_bus.awready) && (!data_bus.wvalid || data_bus.wready)) begin
                  data_bus.bready <= 1'b1;
                  state           <= ST_B;
               end
            end
            ST_B: if (data_bus.bvalid) begin
               data_bus.bready  <= 1'b0;
               state            <= ST_DONE;
               lsu_result       <= '0;
               lsu_is_reg_write <= 1'b0;
               lsu_exception    <= (data_bus.bresp != AXI_RESP_OKAY);
            end
            ST_DONE: if (!next_stalled) state <= ST_IDLE;
            default: ;
         endcase

         if (accept) begin
            funct3_q                  <= exec_funct3;
            addr_lo_q                 <= addr_lo_in;
            is_reg_write_q            <= exec_is_reg_write;
            lsu_reg_write_sel         <= exec_reg_write_sel;
            lsu_instruction_next_addr <= exec_instruction_next_addr;
            if (exec_exception || !(exec_is_load || exec_is_store)) begin
               state            <= ST_DONE;
               lsu_result       <= exec_result;
               lsu_is_reg_write <= exec_is_reg_write && !exec_exception;
               lsu_exception    <= exec_exception;
            end else if (mem_exc) begin
               state            <= ST_DONE;
               lsu_result       <= exec_result;
               lsu_is_reg_write <= 1'b0;
               lsu_exception    <= 1'b1;
            end else if (exec_is_load) begin
               state            <= ST_AR;
               bus_addr         <= {exec_result[31:2], 2'b00};
               data_bus.arvalid <= 1'b1;
            end else begin
               state            <= ST_AW_W;
               bus_addr         <= {exec_result[31:2], 2'b00};
               data_bus.awvalid <= 1'b1;
               data_bus.wvalid  <= 1'b1;
               data_bus.wdata   <= lane_wdata;
               data_bus.wstrb   <= lane_wstrb;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected writeback bundles into a scoreboard
// that an independent monitor pops at each writeback handshake; bus fields checked inline.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prev_stalled = 1'b1;
   logic        next_stalled = 1'b0;
   logic        exec_is_load = 1'b0;
   logic        exec_is_store = 1'b0;
   logic [2:0]  exec_funct3 = '0;
   logic [31:0] exec_result = '0;
   logic [31:0] exec_store_data = '0;
   logic        exec_is_reg_write = 1'b0;
   logic [4:0]  exec_reg_write_sel = '0;
   logic        exec_exception = 1'b0;
   logic [31:0] exec_instruction_next_addr = '0;
   logic        stall_prev, stall_next;
   logic [31:0] lsu_result;
   logic        lsu_is_reg_write;
   logic [4:0]  lsu_reg_write_sel;
   logic        lsu_exception;
   logic [31:0] lsu_instruction_next_addr;

   lsu_if bus ();

   lsu dut (
      .clk                        (clk),
      .rst                        (rst),
      .prev_stalled               (prev_stalled),
      .stall_prev                 (stall_prev),
      .next_stalled               (next_stalled),
      .stall_next                 (stall_next),
      .exec_is_load               (exec_is_load),
      .exec_is_store              (exec_is_store),
      .exec_funct3                (exec_funct3),
      .exec_result                (exec_result),
      .exec_store_data            (exec_store_data),
      .exec_is_reg_write          (exec_is_reg_write),
      .exec_reg_write_sel         (exec_reg_write_sel),
      .exec_exception             (exec_exception),
      .exec_instruction_next_addr (exec_instruction_next_addr),
      .lsu_result                 (lsu_result),
      .lsu_is_reg_write           (lsu_is_reg_write),
      .lsu_reg_write_sel          (lsu_reg_write_sel),
      .lsu_exception              (lsu_exception),
      .lsu_instruction_next_addr  (lsu_instruction_next_addr),
      .data_bus                   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      bit          chk_result;
      bit          irw;
      logic [4:0]  sel;
      bit          exc;
      logic [31:0] na;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] result, input bit chk_result, input bit irw,
                           input logic [4:0] sel, input bit exc, input logic [31:0] na);
      exp_t e;
      e.result = result; e.chk_result = chk_result; e.irw = irw;
      e.sel = sel; e.exc = exc; e.na = na;
      sb.push_back(e);
   endtask

   // Monitor: pops on every writeback handshake, checks stability while writeback stalls.
   initial begin
      exp_t        e;
      bit          held;
      logic [31:0] h_res, h_na;
      logic        h_irw, h_exc;
      logic [4:0]  h_sel;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || stall_next) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_result", lsu_result, h_res);
               check("hold_irw", lsu_is_reg_write, h_irw);
               check("hold_sel", lsu_reg_write_sel, h_sel);
               check("hold_exc", lsu_exception, h_exc);
               check("hold_next_addr", lsu_instruction_next_addr, h_na);
            end
            if (next_stalled) begin
               held = 1'b1;
               h_res = lsu_result; h_irw = lsu_is_reg_write; h_sel = lsu_reg_write_sel;
               h_exc = lsu_exception; h_na = lsu_instruction_next_addr;
            end else begin
               held = 1'b0;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fails++;
                  $display("FAIL unexpected_output: got result 0x%08h with empty scoreboard, required no output", lsu_result);
               end else begin
                  e = sb.pop_front();
                  if (e.chk_result) check("wb_result", lsu_result, e.result);
                  check("wb_irw", lsu_is_reg_write, e.irw);
                  check("wb_sel", lsu_reg_write_sel, e.sel);
                  check("wb_exc", lsu_exception, e.exc);
                  check("wb_next_addr", lsu_instruction_next_addr, e.na);
               end
            end
         end
      end
   end

   task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] sd, input bit irw, input logic [4:0] rd,
                        input bit exc, input logic [31:0] na);
      int n = 0;
      @(posedge clk); #1;
      exec_is_load = ld; exec_is_store = st; exec_funct3 = f3; exec_result = res;
      exec_store_data = sd; exec_is_reg_write = irw; exec_reg_write_sel = rd;
      exec_exception = exc; exec_instruction_next_addr = na;
      prev_stalled = 1'b0;
      @(negedge clk);
      while (stall_prev && n < 100) begin @(negedge clk); n++; end
      check("accept_ready", stall_prev, 0);
      @(posedge clk); #1;
      prev_stalled = 1'b1;
   endtask

   task automatic expect_quick();
      @(negedge clk);
      check("one_cycle_latency", stall_next, 0);
   endtask

   task automatic no_bus(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         check("no_bus", {bus.arvalid, bus.awvalid, bus.wvalid}, 0);
      end
   endtask

   task automatic wait_arvalid();
      int n = 0;
      @(negedge clk);
      while (!bus.arvalid && n < 50) begin @(negedge clk); n++; end
      check("arvalid_seen", bus.arvalid, 1);
   endtask

   task automatic wait_rready();
      int n = 0;
      @(negedge clk);
      while (!bus.rready && n < 50) begin @(negedge clk); n++; end
      check("rready_seen", bus.rready, 1);
   endtask

   task automatic serve_read(input int ar_delay, input logic [31:0] rdata, input logic [1:0] rresp,
                             input logic [31:0] exp_addr);
      wait_arvalid();
      check("araddr", bus.araddr, exp_addr);
      check("arprot", bus.arprot, 3'b000);
      for (int i = 0; i < ar_delay; i++) begin
         @(negedge clk);
         check("ar_hold_valid", bus.arvalid, 1);
         check("ar_hold_addr", bus.araddr, exp_addr);
      end
      bus.arready = 1'b1;
      @(posedge clk); #1;
      bus.arready = 1'b0;
      wait_rready();
      check("arvalid_dropped", bus.arvalid, 0);
      bus.rvalid = 1'b1; bus.rdata = rdata; bus.rresp = rresp;
      @(posedge clk); #1;
      bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
   endtask

   task automatic serve_write(input int aw_delay, input int w_delay, input logic [1:0] bresp,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_wstrb);
      int n = 0;
      int last;
      last = (aw_delay > w_delay) ? aw_delay : w_delay;
      @(negedge clk);
      while (!bus.awvalid && n < 50) begin @(negedge clk); n++; end
      check("awvalid_seen", bus.awvalid, 1);
      check("wvalid_seen", bus.wvalid, 1);
      check("awaddr", bus.awaddr, exp_addr);
      check("awprot", bus.awprot, 3'b000);
      check("wdata", bus.wdata, exp_wdata);
      check("wstrb", bus.wstrb, exp_wstrb);
      for (int c = 0; c <= last; c++) begin
         if (c > 0) @(negedge clk);
         if (c > w_delay)  check("wvalid_dropped_early", bus.wvalid, 0);
         if (c > aw_delay) check("awvalid_dropped_early", bus.awvalid, 0);
         check("no_bready_yet", bus.bready, 0);
         bus.wready  = (c == w_delay);
         bus.awready = (c == aw_delay);
         @(posedge clk); #1;
         bus.wready = 1'b0; bus.awready = 1'b0;
      end
      n = 0;
      @(negedge clk);
      while (!bus.bready && n < 50) begin @(negedge clk); n++; end
      check("bready_seen", bus.bready, 1);
      check("aw_w_idle", {bus.awvalid, bus.wvalid}, 0);
      bus.bvalid = 1'b1; bus.bresp = bresp;
      @(posedge clk); #1;
      bus.bvalid = 1'b0; bus.bresp = '0;
      @(negedge clk);
      check("bready_dropped", bus.bready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_aresetn", bus.aresetn, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_stall_next", stall_next, 1);
      check("rst_stall_prev", stall_prev, 0);
      check("rst_bus_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 0);
      check("rst_outputs", {lsu_is_reg_write, lsu_exception, lsu_reg_write_sel}, 0);
      check("rst_result", lsu_result, 0);
      check("aresetn_released", bus.aresetn, 1);

      // ALU pass-through
      push_exp(32'h0000_1234, 1, 1, 5'd5, 0, 32'h0000_0044);
      issue(0, 0, 3'b000, 32'h0000_1234, 32'h0, 1, 5'd5, 0, 32'h0000_0044);
      expect_quick();
      no_bus(3);

      // LB 0x103, arready after 3 cycles
      push_exp(32'hFFFF_FF80, 1, 1, 5'd7, 0, 32'h0000_0048);
      issue(1, 0, LSU_B, 32'h0000_0103, 32'h0, 1, 5'd7, 0, 32'h0000_0048);
      serve_read(3, 32'h80FF_FF00, 2'b00, 32'h0000_0100);

      // SH 0x202, wready two cycles before awready
      push_exp(32'h0, 1, 0, 5'd2, 0, 32'h0000_004C);
      issue(0, 1, LSU_H, 32'h0000_0202, 32'h0000_ABCD, 0, 5'd2, 0, 32'h0000_004C);
      serve_write(2, 0, 2'b00, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100);

      // LW with SLVERR while writeback stalls for 4 cycles
      @(posedge clk); #1;
      next_stalled = 1'b1;
      push_exp(32'h0, 0, 0, 5'd9, 1, 32'h0000_0050);
      issue(1, 0, LSU_W, 32'h0000_0300, 32'h0, 1, 5'd9, 0, 32'h0000_0050);
      serve_read(0, 32'h1111_1111, 2'b10, 32'h0000_0300);
      begin
         int n = 0;
         @(negedge clk);
         while (stall_next && n < 20) begin @(negedge clk); n++; end
         check("err_done_reached", stall_next, 0);
      end
      check("done_stalled_blocks_input", stall_prev, 1);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      next_stalled = 1'b0;

      // LW 0x101 misaligned
`ifdef LSU_MISALIGN_TRAP_EN
      push_exp(32'h0, 0, 0, 5'd10, 1, 32'h0000_0054);
      issue(1, 0, LSU_W, 32'h0000_0101, 32'h0, 1, 5'd10, 0, 32'h0000_0054);
      expect_quick();
      no_bus(3);
`else
      push_exp(32'hDEAD_BEEF, 1, 1, 5'd10, 0, 32'h0000_0054);
      issue(1, 0, LSU_W, 32'h0000_0101, 32'h0, 1, 5'd10, 0, 32'h0000_0054);
      serve_read(0, 32'hDEAD_BEEF, 2'b00, 32'h0000_0100);
`endif

      // LHU / LH upper half
      push_exp(32'h0000_8001, 1, 1, 5'd11, 0, 32'h0000_0058);
      issue(1, 0, LSU_HU, 32'h0000_0002, 32'h0, 1, 5'd11, 0, 32'h0000_0058);
      serve_read(1, 32'h8001_0000, 2'b00, 32'h0000_0000);
      push_exp(32'hFFFF_8001, 1, 1, 5'd12, 0, 32'h0000_005C);
      issue(1, 0, LSU_H, 32'h0000_0002, 32'h0, 1, 5'd12, 0, 32'h0000_005C);
      serve_read(0, 32'h8001_0000, 2'b00, 32'h0000_0000);

      // SB with SLVERR, SW clean
      push_exp(32'h0, 1, 0, 5'd13, 1, 32'h0000_0060);
      issue(0, 1, LSU_B, 32'h0000_0001, 32'hFFFF_FF12, 0, 5'd13, 0, 32'h0000_0060);
      serve_write(1, 1, 2'b10, 32'h0000_0000, 32'h1212_1212, 4'b0010);
      push_exp(32'h0, 1, 0, 5'd14, 0, 32'h0000_0064);
      issue(0, 1, LSU_W, 32'h0000_0008, 32'hCAFE_F00D, 0, 5'd14, 0, 32'h0000_0064);
      serve_write(0, 1, 2'b00, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111);

      // Unused funct3 on a load, upstream exception on a store
      push_exp(32'h0, 0, 0, 5'd15, 1, 32'h0000_0068);
      issue(1, 0, 3'b011, 32'h0000_0010, 32'h0, 1, 5'd15, 0, 32'h0000_0068);
      expect_quick();
      no_bus(2);
      push_exp(32'h0000_0020, 1, 0, 5'd16, 1, 32'h0000_006C);
      issue(0, 1, LSU_W, 32'h0000_0020, 32'h5555_5555, 0, 5'd16, 1, 32'h0000_006C);
      expect_quick();
      no_bus(2);

      // Back-to-back LBU then ALU op accepted in the DONE cycle
      push_exp(32'h0000_00A5, 1, 1, 5'd3, 0, 32'h0000_0070);
      push_exp(32'h0000_0077, 1, 1, 5'd9, 0, 32'h0000_0074);
      issue(1, 0, LSU_BU, 32'h0000_0000, 32'h0, 1, 5'd3, 0, 32'h0000_0070);
      exec_is_load = 1'b0; exec_is_store = 1'b0; exec_funct3 = 3'b000;
      exec_result = 32'h0000_0077; exec_is_reg_write = 1'b1; exec_reg_write_sel = 5'd9;
      exec_exception = 1'b0; exec_instruction_next_addr = 32'h0000_0074;
      prev_stalled = 1'b0;
      serve_read(0, 32'h1234_56A5, 2'b00, 32'h0000_0000);
      @(negedge clk);
      check("b2b_done_valid", stall_next, 0);
      check("b2b_accept_in_done", stall_prev, 0);
      @(posedge clk); #1;
      prev_stalled = 1'b1;
      @(negedge clk);
      check("b2b_second_valid", stall_next, 0);

      // Reset while the next load waits in R
      issue(1, 0, LSU_W, 32'h0000_0040, 32'h0, 1, 5'd4, 0, 32'h0000_0078);
      wait_arvalid();
      bus.arready = 1'b1;
      @(posedge clk); #1;
      bus.arready = 1'b0;
      wait_rready();
      rst = 1'b1;
      #1;
      check("mid_reset_aresetn", bus.aresetn, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_state", 32'(dut.state), 32'(ST_IDLE));
      check("post_rst_rready", bus.rready, 0);
      check("post_rst_stall_next", stall_next, 1);
      check("post_rst_stall_prev", stall_prev, 0);
      check("post_rst_arvalid", bus.arvalid, 0);
      check("post_rst_result", lsu_result, 0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
